// File: rtl/cix32_defines.sv
// Shared trap-controller types and architectural constants for the CIX-32 core.
package cix32_defines;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_CR2_WR,
        ST_DISPATCH,
        ST_SHUTDOWN
    } trap_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EXC,
        SRC_NMI,
        SRC_INT
    } trap_src_t;

    localparam logic [7:0] PF_VECTOR  = 8'd14;
    localparam logic [7:0] DF_VECTOR  = 8'd8;
    localparam logic [7:0] NMI_VECTOR = 8'd2;
    localparam logic [2:0] CR2_ADDR   = 3'h2;

endpackage

// File: rtl/cix32_trap_controller_if.sv
// Trap-controller bundle: requester req/ack pairs, CR write port, dispatch valid/ready, iret and shutdown.
interface cix32_trap_controller_if;

    logic        exception_req;
    logic [7:0]  exception_vector;
    logic [31:0] exception_addr;
    logic        exception_ack;
    logic        nmi_req;
    logic        nmi_ack;
    logic        interrupt_req;
    logic [7:0]  interrupt_vector;
    logic        interrupt_ack;
    logic        interrupt_enabled;
    logic [2:0]  cr_addr;
    logic [31:0] cr_wdata;
    logic        cr_we;
    logic        trap_valid;
    logic [7:0]  trap_vector;
    logic        trap_ready;
    logic        iret_done;
    logic        shutdown;

    // master: the trap controller itself
    modport master (
        input  exception_req, exception_vector, exception_addr,
        input  nmi_req, interrupt_req, interrupt_vector, interrupt_enabled,
        input  trap_ready, iret_done,
        output exception_ack, nmi_ack, interrupt_ack,
        output cr_addr, cr_wdata, cr_we,
        output trap_valid, trap_vector, shutdown
    );

    // slave: requesters, CR file and dispatch
    modport slave (
        output exception_req, exception_vector, exception_addr,
        output nmi_req, interrupt_req, interrupt_vector, interrupt_enabled,
        output trap_ready, iret_done,
        input  exception_ack, nmi_ack, interrupt_ack,
        input  cr_addr, cr_wdata, cr_we,
        input  trap_valid, trap_vector, shutdown
    );

endinterface

// File: rtl/cix32_trap_controller.sv
// Trap entry sequencer: arbitrates exc > NMI > INT, writes CR2 on #PF, escalates to #DF / shutdown.
// Latency: ack at N+1, trap_valid at N+2 (N+3 for #PF); trap_valid/trap_vector held until trap_ready.
module cix32_trap_controller
    import cix32_defines::*;
(
    input  logic                    clk,
    input  logic                    rst,
    cix32_trap_controller_if.master bus
);

    trap_state_t state_q, state_d;
    trap_src_t   src_q, src_d;
    logic [7:0]  vec_q, vec_d;
    logic [31:0] addr_q, addr_d;
    logic        promo_q, promo_d;
    logic        df_active_q, df_active_d;
    logic        nmi_blocked_q, nmi_blocked_d;

    trap_src_t   win_src;
    logic [7:0]  win_vec;
    logic        handshake;
    logic        nested;

    // Priority select, only consumed in IDLE
    always_comb begin
        win_src = SRC_NONE;
        win_vec = 8'h00;
        if (bus.exception_req) begin
            win_src = SRC_EXC;
            win_vec = bus.exception_vector;
        end else if (bus.nmi_req && !nmi_blocked_q) begin
            win_src = SRC_NMI;
            win_vec = NMI_VECTOR;
        end else if (bus.interrupt_req && bus.interrupt_enabled) begin
            win_src = SRC_INT;
            win_vec = bus.interrupt_vector;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            src_q         <= SRC_NONE;
            vec_q         <= 8'h00;
            addr_q        <= 32'h0;
            promo_q       <= 1'b0;
            df_active_q   <= 1'b0;
            nmi_blocked_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            vec_q         <= vec_d;
            addr_q        <= addr_d;
            promo_q       <= promo_d;
            df_active_q   <= df_active_d;
            nmi_blocked_q <= nmi_blocked_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        vec_d         = vec_q;
        addr_d        = addr_q;
        promo_d       = promo_q;
        df_active_d   = df_active_q;
        nmi_blocked_d = nmi_blocked_q;
        nested        = 1'b0;
        handshake     = (state_q == ST_DISPATCH) && bus.trap_ready;

        if (bus.iret_done) nmi_blocked_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_src != SRC_NONE) begin
                    state_d = ST_ACCEPT;
                    src_d   = win_src;
                    vec_d   = win_vec;
                    promo_d = 1'b0;
                    if (win_src == SRC_EXC) addr_d = bus.exception_addr;
                end
            end
            ST_ACCEPT: begin
                // An exception being acked this cycle is ours, not a nested fault
                nested = bus.exception_req && (src_q != SRC_EXC);
                if (src_q == SRC_NMI) nmi_blocked_d = 1'b1;
                state_d = (vec_q == PF_VECTOR && !promo_q) ? ST_CR2_WR : ST_DISPATCH;
            end
            ST_CR2_WR: begin
                nested  = bus.exception_req;
                state_d = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (handshake) begin
                    state_d     = ST_IDLE;
                    df_active_d = 1'b0;
                end else begin
                    nested = bus.exception_req;
                end
            end
            ST_SHUTDOWN: state_d = ST_SHUTDOWN;
            default:     state_d = ST_IDLE;
        endcase

        if (nested) begin
            if (df_active_q) begin
                state_d = ST_SHUTDOWN;
            end else begin
                state_d     = ST_ACCEPT;
                src_d       = SRC_EXC;
                vec_d       = DF_VECTOR;
                promo_d     = 1'b1;
                df_active_d = 1'b1;
            end
        end
    end

    assign bus.exception_ack = (state_q == ST_ACCEPT) && (src_q == SRC_EXC);
    assign bus.nmi_ack       = (state_q == ST_ACCEPT) && (src_q == SRC_NMI);
    assign bus.interrupt_ack = (state_q == ST_ACCEPT) && (src_q == SRC_INT);
    assign bus.cr_we         = (state_q == ST_CR2_WR);
    assign bus.cr_addr       = bus.cr_we ? CR2_ADDR : 3'h0;
    assign bus.cr_wdata      = bus.cr_we ? addr_q : 32'h0;
    assign bus.trap_valid    = (state_q == ST_DISPATCH);
    assign bus.trap_vector   = bus.trap_valid ? vec_q : 8'h00;
    assign bus.shutdown      = (state_q == ST_SHUTDOWN);

endmodule

// File: tb/tb_cix32_trap_controller.sv
// Directed bench for the trap controller; inputs driven and outputs sampled on the falling edge.
module tb_cix32_trap_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cix32_trap_controller_if bus();

    cix32_trap_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_handshake();
        bus.trap_ready = 1'b1;
        tick();
        bus.trap_ready = 1'b0;
    endtask

    task automatic iret_pulse();
        bus.iret_done = 1'b1;
        tick();
        bus.iret_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_eack"},  {31'b0, bus.exception_ack}, 32'h0);
        chk({tag, "_nack"},  {31'b0, bus.nmi_ack},       32'h0);
        chk({tag, "_iack"},  {31'b0, bus.interrupt_ack}, 32'h0);
        chk({tag, "_crwe"},  {31'b0, bus.cr_we},         32'h0);
        chk({tag, "_craddr"},{29'b0, bus.cr_addr},       32'h0);
        chk({tag, "_crwd"},  bus.cr_wdata,               32'h0);
        chk({tag, "_tval"},  {31'b0, bus.trap_valid},    32'h0);
        chk({tag, "_tvec"},  {24'b0, bus.trap_vector},   32'h0);
        chk({tag, "_shut"},  {31'b0, bus.shutdown},      32'h0);
    endtask

    initial begin
        int seen;
        checks   = 0;
        failures = 0;
        rst                   = 1'b1;
        bus.exception_req     = 1'b0;
        bus.exception_vector  = 8'h00;
        bus.exception_addr    = 32'h0;
        bus.nmi_req           = 1'b0;
        bus.interrupt_req     = 1'b0;
        bus.interrupt_vector  = 8'h00;
        bus.interrupt_enabled = 1'b0;
        bus.trap_ready        = 1'b0;
        bus.iret_done         = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Interrupt 0x20, dispatch held off for three cycles
        bus.interrupt_req     = 1'b1;
        bus.interrupt_vector  = 8'h20;
        bus.interrupt_enabled = 1'b1;
        tick();
        chk("int_ack_c1", {31'b0, bus.interrupt_ack}, 32'h1);
        chk("int_eack_c1", {31'b0, bus.exception_ack}, 32'h0);
        chk("int_tval_c1", {31'b0, bus.trap_valid}, 32'h0);
        bus.interrupt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("int_tval_hold", {31'b0, bus.trap_valid}, 32'h1);
            chk("int_tvec_hold", {24'b0, bus.trap_vector}, 32'h20);
            chk("int_ack_gone", {31'b0, bus.interrupt_ack}, 32'h0);
        end
        do_handshake();
        chk("int_idle_after_hs", {31'b0, bus.trap_valid}, 32'h0);

        // Page fault: CR2 write then vector 14
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd14;
        bus.exception_addr   = 32'hDEAD_B000;
        tick();
        chk("pf_eack_c1", {31'b0, bus.exception_ack}, 32'h1);
        chk("pf_crwe_c1", {31'b0, bus.cr_we}, 32'h0);
        bus.exception_req = 1'b0;
        tick();
        chk("pf_crwe_c2", {31'b0, bus.cr_we}, 32'h1);
        chk("pf_craddr_c2", {29'b0, bus.cr_addr}, 32'h2);
        chk("pf_crwd_c2", bus.cr_wdata, 32'hDEAD_B000);
        chk("pf_tval_c2", {31'b0, bus.trap_valid}, 32'h0);
        chk("pf_eack_c2", {31'b0, bus.exception_ack}, 32'h0);
        tick();
        chk("pf_tval_c3", {31'b0, bus.trap_valid}, 32'h1);
        chk("pf_tvec_c3", {24'b0, bus.trap_vector}, 32'd14);
        chk("pf_crwe_c3", {31'b0, bus.cr_we}, 32'h0);
        do_handshake();

        // Exception 13 + NMI + interrupt 0x21 together
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd13;
        bus.nmi_req          = 1'b1;
        bus.interrupt_req    = 1'b1;
        bus.interrupt_vector = 8'h21;
        tick();
        chk("all3_eack", {31'b0, bus.exception_ack}, 32'h1);
        chk("all3_nack0", {31'b0, bus.nmi_ack}, 32'h0);
        chk("all3_iack0", {31'b0, bus.interrupt_ack}, 32'h0);
        bus.exception_req = 1'b0;
        tick();
        chk("all3_tvec13", {24'b0, bus.trap_vector}, 32'd13);
        chk("all3_nack_disp", {31'b0, bus.nmi_ack}, 32'h0);
        do_handshake();
        tick();
        chk("all3_nack", {31'b0, bus.nmi_ack}, 32'h1);
        chk("all3_iack_nmi", {31'b0, bus.interrupt_ack}, 32'h0);
        bus.nmi_req = 1'b0;
        tick();
        chk("all3_tvec2", {24'b0, bus.trap_vector}, 32'd2);
        do_handshake();
        tick();
        chk("all3_iack", {31'b0, bus.interrupt_ack}, 32'h1);
        bus.interrupt_req = 1'b0;
        tick();
        chk("all3_tvec21", {24'b0, bus.trap_vector}, 32'h21);
        do_handshake();

        // NMI stays blocked until iret_done, then is accepted two cycles later
        bus.nmi_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.nmi_ack) seen++;
        end
        chk("nmi_blocked_no_ack", seen, 0);
        iret_pulse();
        chk("nmi_iret_c1", {31'b0, bus.nmi_ack}, 32'h0);
        tick();
        chk("nmi_iret_c2", {31'b0, bus.nmi_ack}, 32'h1);
        bus.nmi_req = 1'b0;
        tick();
        chk("nmi_tvec", {24'b0, bus.trap_vector}, 32'd2);
        do_handshake();
        iret_pulse();

        // Same mix with interrupts masked
        bus.interrupt_enabled = 1'b0;
        bus.exception_req     = 1'b1;
        bus.exception_vector  = 8'd13;
        bus.nmi_req           = 1'b1;
        bus.interrupt_req     = 1'b1;
        seen = 0;
        tick();
        chk("mask_eack", {31'b0, bus.exception_ack}, 32'h1);
        bus.exception_req = 1'b0;
        tick();
        do_handshake();
        tick();
        chk("mask_nack", {31'b0, bus.nmi_ack}, 32'h1);
        bus.nmi_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) bus.trap_ready = 1'b1;
            tick();
            bus.trap_ready = 1'b0;
            if (bus.interrupt_ack) seen++;
        end
        chk("mask_no_iack", seen, 0);
        chk("mask_idle", {31'b0, bus.trap_valid}, 32'h0);
        bus.interrupt_req     = 1'b0;
        bus.interrupt_enabled = 1'b1;
        iret_pulse();

        // Handshake coincident with a new exception
        bus.interrupt_req    = 1'b1;
        bus.interrupt_vector = 8'h30;
        tick();
        bus.interrupt_req = 1'b0;
        tick();
        chk("hsx_tvec30", {24'b0, bus.trap_vector}, 32'h30);
        bus.trap_ready       = 1'b1;
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd13;
        tick();
        bus.trap_ready = 1'b0;
        chk("hsx_idle", {31'b0, bus.trap_valid}, 32'h0);
        chk("hsx_no_ack_yet", {31'b0, bus.exception_ack}, 32'h0);
        tick();
        chk("hsx_eack", {31'b0, bus.exception_ack}, 32'h1);
        bus.exception_req = 1'b0;
        tick();
        chk("hsx_tvec13", {24'b0, bus.trap_vector}, 32'd13);
        do_handshake();

        // Escalation: #PF dispatch, nested fault -> #DF, another -> shutdown
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd14;
        bus.exception_addr   = 32'h1234_5000;
        tick();
        bus.exception_req = 1'b0;
        tick();
        chk("esc_crwe", {31'b0, bus.cr_we}, 32'h1);
        tick();
        chk("esc_tvec14", {24'b0, bus.trap_vector}, 32'd14);
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd13;
        tick();
        chk("esc_reack", {31'b0, bus.exception_ack}, 32'h1);
        chk("esc_tval_drop", {31'b0, bus.trap_valid}, 32'h0);
        chk("esc_no_crwe_acc", {31'b0, bus.cr_we}, 32'h0);
        bus.exception_req = 1'b0;
        tick();
        chk("esc_tvec8", {24'b0, bus.trap_vector}, 32'd8);
        chk("esc_no_crwe_disp", {31'b0, bus.cr_we}, 32'h0);
        chk("esc_shut0", {31'b0, bus.shutdown}, 32'h0);
        bus.exception_req = 1'b1;
        tick();
        chk("esc_shut", {31'b0, bus.shutdown}, 32'h1);
        chk("esc_shut_tval", {31'b0, bus.trap_valid}, 32'h0);
        chk("esc_shut_eack", {31'b0, bus.exception_ack}, 32'h0);
        bus.exception_req = 1'b0;
        bus.trap_ready    = 1'b1;
        tick();
        tick();
        bus.trap_ready = 1'b0;
        tick();
        chk("esc_shut_sticky", {31'b0, bus.shutdown}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("esc_rst_shut", {31'b0, bus.shutdown}, 32'h0);
        tick();

        // Reset while in CR2_WR
        bus.exception_req    = 1'b1;
        bus.exception_vector = 8'd14;
        bus.exception_addr   = 32'hCAFE_F000;
        tick();
        bus.exception_req = 1'b0;
        tick();
        chk("rcr_crwe_before", {31'b0, bus.cr_we}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rcr");
        tick();
        chk("rcr_no_crwe", {31'b0, bus.cr_we}, 32'h0);
        chk("rcr_no_tval", {31'b0, bus.trap_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
